// File: rtl/pio_mem_req_seq.sv
// Purpose : host PIO request sequencer; decodes one host access to a RAM bank, strobes it, waits for its ack.
// Latency : bank hit acks 3 + bank ack delay cycles after the request; decode errors ack 1 cycle after.
// Backpress: single outstanding access; pio_busy is high outside IDLE and requests seen while busy are dropped.
//
// Ports:
//   clk, rst_n                        core clock, asynchronous active-low reset
//   pio_rd/pio_wr/pio_addr/pio_wdata  host request (1-cycle pulse)
//   pio_busy/pio_ack/pio_err/pio_rdata host response (ack is a 1-cycle pulse, rdata held between acks)
//   clk_div                           divided strobe shared with all banks
//   reg_addr/reg_din/reg_rd/reg_wr/reg_ms  bank request; strobes live only in ISSUE
//   mem_ack/mem_rdata                 per-bank level ack and read data (bank i at [32*i +: 32])
module pio_mem_req_seq #(
    parameter int          N_MEM        = 4,
    parameter int          SEL_NBITS    = 2,
    parameter int          REGION_NBITS = 12,
    parameter logic [31:0] BASE_ADDR    = 32'h0,
    parameter int          TIMEOUT      = 255,
    parameter int          CLK_DIV      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pio_rd,
    input  logic                  pio_wr,
    input  logic [31:0]           pio_addr,
    input  logic [31:0]           pio_wdata,
    output logic                  pio_busy,
    output logic                  pio_ack,
    output logic                  pio_err,
    output logic [31:0]           pio_rdata,
    output logic                  clk_div,
    output logic [31:0]           reg_addr,
    output logic [31:0]           reg_din,
    output logic                  reg_rd,
    output logic                  reg_wr,
    output logic [N_MEM-1:0]      reg_ms,
    input  logic [N_MEM-1:0]      mem_ack,
    input  logic [32*N_MEM-1:0]   mem_rdata
);

    localparam int          TOP_LSB = REGION_NBITS + SEL_NBITS;
    localparam int          DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [7:0]  TMO     = 8'(TIMEOUT);
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_ERR, S_DRAIN
    } state_t;

    state_t                    state_q, state_d;
    logic [REGION_NBITS-1:0]   addr_q, addr_d;
    logic [31:0]               wdata_q, wdata_d;
    logic [SEL_NBITS-1:0]      sel_q, sel_d;
    logic                      rd_q, rd_d;      // direction of the latched access
    logic                      acc_q, acc_d;    // latched access really targets a bank
    logic [7:0]                tcnt_q, tcnt_d;
    logic [N_MEM-1:0]          ack_prev_q, ack_prev_d;
    logic [31:0]               rdata_q, rdata_d;
    logic [DIV_W-1:0]          div_cnt_q, div_cnt_d;
    logic                      clk_div_q, clk_div_d;

    logic                      req;
    logic                      base_hit;
    logic                      sel_in_range;
    logic [SEL_NBITS-1:0]      sel_in;
    logic                      ack_sel;
    logic                      ack_prev_sel;
    logic [31:0]               rdata_sel;
    logic                      ack_rise;
    logic                      tmo;

    assign req      = pio_rd | pio_wr;
    assign sel_in   = pio_addr[TOP_LSB-1:REGION_NBITS];
    assign base_hit = (pio_addr[31:TOP_LSB] == BASE_ADDR[31:TOP_LSB]);
    assign tmo      = (tcnt_q == TMO);

    // Bank-indexed views. Looping over real banks keeps an out-of-range
    // select from indexing past the bus and reads it as "no ack".
    always_comb begin
        sel_in_range = 1'b0;
        ack_sel      = 1'b0;
        ack_prev_sel = 1'b0;
        rdata_sel    = '0;
        for (int i = 0; i < N_MEM; i++) begin
            if (sel_in == SEL_NBITS'(i)) begin
                sel_in_range = 1'b1;
            end
            if (acc_q && (sel_q == SEL_NBITS'(i))) begin
                ack_sel      = mem_ack[i];
                ack_prev_sel = ack_prev_q[i];
                rdata_sel    = mem_rdata[32*i +: 32];
            end
        end
    end

    // Only a fresh 0->1 transition completes; a stretched ack left over
    // from an earlier access stays high and is never mistaken for a new one.
    assign ack_rise   = ack_sel & ~ack_prev_sel;
    assign ack_prev_d = mem_ack;

    // Free-running divider; clk_div is registered so it is low during reset
    // even when CLK_DIV == 1.
    always_comb begin
        div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);
        clk_div_d = (div_cnt_d == DIV_LAST);
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        sel_d   = sel_q;
        rd_d    = rd_q;
        acc_d   = acc_q;
        tcnt_d  = tcnt_q;
        rdata_d = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d  = pio_addr[REGION_NBITS-1:0];
                    wdata_d = pio_wdata;
                    sel_d   = sel_in;
                    rd_d    = pio_rd;
                    if (base_hit && sel_in_range && !(pio_rd && pio_wr)) begin
                        acc_d   = 1'b1;
                        state_d = S_ISSUE;
                    end else begin
                        acc_d   = 1'b0;
                        state_d = S_ERR;
                        if (pio_rd) begin
                            rdata_d = ERR_DATA;
                        end
                    end
                end
            end
            S_ISSUE: begin
                tcnt_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (ack_rise) begin
                    if (rd_q) begin
                        rdata_d = rdata_sel;
                    end
                    state_d = S_DONE;
                end else if (tmo) begin
                    if (rd_q) begin
                        rdata_d = ERR_DATA;
                    end
                    state_d = S_ERR;
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                end
            end
            S_DONE, S_ERR: begin
                tcnt_d  = '0;
                state_d = S_DRAIN;
            end
            S_DRAIN: begin
                // Hold off new requests until the bank drops its ack, so a
                // stretched ack cannot be sampled by the next access.
                if (!ack_sel || tmo) begin
                    state_d = S_IDLE;
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            sel_q      <= '0;
            rd_q       <= 1'b0;
            acc_q      <= 1'b0;
            tcnt_q     <= '0;
            ack_prev_q <= '0;
            rdata_q    <= '0;
            div_cnt_q  <= '0;
            clk_div_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            sel_q      <= sel_d;
            rd_q       <= rd_d;
            acc_q      <= acc_d;
            tcnt_q     <= tcnt_d;
            ack_prev_q <= ack_prev_d;
            rdata_q    <= rdata_d;
            div_cnt_q  <= div_cnt_d;
            clk_div_q  <= clk_div_d;
        end
    end

    assign pio_busy  = (state_q != S_IDLE);
    assign pio_ack   = (state_q == S_DONE) || (state_q == S_ERR);
    assign pio_err   = (state_q == S_ERR);
    assign pio_rdata = rdata_q;
    assign clk_div   = clk_div_q;
    assign reg_addr  = {{(32-REGION_NBITS){1'b0}}, addr_q};
    assign reg_din   = wdata_q;
    assign reg_rd    = (state_q == S_ISSUE) &&  rd_q;
    assign reg_wr    = (state_q == S_ISSUE) && !rd_q;

    always_comb begin
        reg_ms = '0;
        for (int i = 0; i < N_MEM; i++) begin
            reg_ms[i] = (state_q == S_ISSUE) && (sel_q == SEL_NBITS'(i));
        end
    end

endmodule

// File: tb/tb_pio_mem_req_seq.sv
// Bench for pio_mem_req_seq: behavioural RAM banks with programmable ack delay/hold,
// a scoreboard of expected host responses, and directed access sequences.
// Runs with CLK_DIV=4 and the default TIMEOUT of 255.
module tb_pio_mem_req_seq;

    localparam int N_MEM   = 4;
    localparam int CLK_DIV = 4;
    localparam int TIMEOUT = 255;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 pio_rd = 1'b0;
    logic                 pio_wr = 1'b0;
    logic [31:0]          pio_addr = '0;
    logic [31:0]          pio_wdata = '0;
    logic                 pio_busy, pio_ack, pio_err, clk_div;
    logic [31:0]          pio_rdata, reg_addr, reg_din;
    logic                 reg_rd, reg_wr;
    logic [N_MEM-1:0]     reg_ms;
    logic [N_MEM-1:0]     mem_ack;
    logic [32*N_MEM-1:0]  mem_rdata;

    always #5 clk = ~clk;

    pio_mem_req_seq #(
        .N_MEM(N_MEM), .SEL_NBITS(2), .REGION_NBITS(12), .BASE_ADDR(32'h0),
        .TIMEOUT(TIMEOUT), .CLK_DIV(CLK_DIV)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .pio_rd(pio_rd), .pio_wr(pio_wr), .pio_addr(pio_addr), .pio_wdata(pio_wdata),
        .pio_busy(pio_busy), .pio_ack(pio_ack), .pio_err(pio_err), .pio_rdata(pio_rdata),
        .clk_div(clk_div), .reg_addr(reg_addr), .reg_din(reg_din),
        .reg_rd(reg_rd), .reg_wr(reg_wr), .reg_ms(reg_ms),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    // ---------------- behavioural banks (not reset: late acks survive a DUT reset)
    logic [31:0] bank_mem [N_MEM][1024];
    logic [31:0] bank_rd  [N_MEM];
    int          dly_cnt  [N_MEM];
    int          hold_cnt [N_MEM];
    int          ack_dly  [N_MEM];
    int          ack_hold [N_MEM];
    bit          bank_en  [N_MEM];

    always_comb begin
        for (int i = 0; i < N_MEM; i++) begin
            mem_ack[i]             = (hold_cnt[i] > 0);
            mem_rdata[32*i +: 32]  = bank_rd[i];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < N_MEM; i++) begin
            if (reg_ms[i] && bank_en[i]) begin
                if (reg_wr) bank_mem[i][reg_addr[11:2]] <= reg_din;
                if (reg_rd) bank_rd[i] <= bank_mem[i][reg_addr[11:2]];
                dly_cnt[i] <= ack_dly[i];
            end else if (dly_cnt[i] > 0) begin
                dly_cnt[i] <= dly_cnt[i] - 1;
                if (dly_cnt[i] == 1) hold_cnt[i] <= ack_hold[i];
            end else if (hold_cnt[i] > 0) begin
                hold_cnt[i] <= hold_cnt[i] - 1;
            end
        end
    end

    // ---------------- scoreboard and counters
    typedef struct {
        logic        err;
        bit          chk_rd;
        logic [31:0] rdata;
        int          id;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          next_id = 0;
    int          ack_cnt = 0, ms_cyc = 0, rd_cyc = 0, wr_cyc = 0;
    logic [3:0]  last_ms = '0;
    logic [31:0] last_addr = '0, last_din = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per pio_ack and tracks bank strobes.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (reg_ms != '0) begin
                    ms_cyc++;
                    last_ms   = reg_ms;
                    last_addr = reg_addr;
                    last_din  = reg_din;
                end
                if (reg_rd) rd_cyc++;
                if (reg_wr) wr_cyc++;
                if (pio_ack) begin
                    ack_cnt++;
                    vectors++;
                    if (sb.size() == 0) begin
                        miscompares++;
                        $display("FAIL unexpected_ack: err=%0b rdata=%h, no ack expected", pio_err, pio_rdata);
                    end else begin
                        e = sb.pop_front();
                        if (pio_err !== e.err || (e.chk_rd && pio_rdata !== e.rdata)) begin
                            miscompares++;
                            $display("FAIL ack_%0d: err=%0b rdata=%h, expected err=%0b rdata=%h%s",
                                     e.id, pio_err, pio_rdata, e.err, e.rdata, e.chk_rd ? "" : " (rdata not checked)");
                        end
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers (called just after a negedge)
    task automatic pulse(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        pio_rd = rd; pio_wr = wr; pio_addr = a; pio_wdata = d;
        @(negedge clk);
        pio_rd = 1'b0; pio_wr = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (pio_busy && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_idle"}, 32'(pio_busy), 32'h0);
    endtask

    // Issues one access and expects its ack exp_lat cycles after the request
    // cycle (0 = do not check latency).
    task automatic access(input string name, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic exp_err, input bit chk_rd, input logic [31:0] exp_rd,
                          input int exp_lat);
        exp_t e;
        int n;
        e.err = exp_err; e.chk_rd = chk_rd; e.rdata = exp_rd; e.id = next_id;
        next_id++;
        sb.push_back(e);
        @(negedge clk);
        pulse(rd, wr, a, d);
        n = 1;
        while (!pio_ack && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (exp_lat > 0) chk({name, "_lat"}, 32'(n), 32'(exp_lat));
        wait_idle(name);
    endtask

    // ---------------- directed sequence
    initial begin
        int ms0, wr0, ack0;
        for (int i = 0; i < N_MEM; i++) begin
            bank_en[i] = 1'b1; ack_dly[i] = 2; ack_hold[i] = 1;
        end

        // Reset state
        #1;
        chk("rst_ctrl", 32'({pio_busy, pio_ack, pio_err, clk_div, reg_rd, reg_wr, reg_ms}), 32'h0);
        chk("rst_rdata", pio_rdata, 32'h0);
        chk("rst_addr", reg_addr | reg_din, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // clk_div: high on every 4th cycle, starting 3 cycles after release
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk($sformatf("clk_div_%0d", k), 32'(clk_div), 32'((k % 4) == 3));
        end

        // 1) write then read back via bank 1
        ack_dly[1] = 4;
        ms0 = ms_cyc; wr0 = wr_cyc;
        access("t1_wr", 1'b0, 1'b1, 32'h1008, 32'h1234, 1'b0, 1'b1, 32'h0, 7);
        chk("t1_ms_cycles", 32'(ms_cyc - ms0), 32'd1);
        chk("t1_wr_cycles", 32'(wr_cyc - wr0), 32'd1);
        chk("t1_reg_ms", 32'(last_ms), 32'h2);
        chk("t1_reg_addr", last_addr, 32'h8);
        chk("t1_reg_din", last_din, 32'h1234);
        access("t1_rd", 1'b1, 1'b0, 32'h1008, 32'h0, 1'b0, 1'b1, 32'h1234, 7);

        // 2) bank 2 never acks -> timeout error
        bank_en[2] = 1'b0;
        access("t2_tmo", 1'b1, 1'b0, 32'h2000, 32'h0, 1'b1, 1'b1, 32'hDEAD_BEEF, TIMEOUT + 3);
        bank_en[2] = 1'b1;

        // 3) decode errors: base miss and rd&wr together
        ms0 = ms_cyc;
        access("t3_miss", 1'b1, 1'b0, 32'h0001_0000, 32'h0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1);
        access("t3_rdwr", 1'b1, 1'b1, 32'h1008, 32'h0, 1'b1, 1'b0, 32'h0, 1);
        chk("t3_no_ms", 32'(ms_cyc - ms0), 32'd0);

        // 4) stretched acks (4 cycles) and back-to-back reads to bank 1; bank 3 too
        ack_hold[1] = 4; ack_dly[1] = 2;
        ack0 = ack_cnt;
        access("t4_wr", 1'b0, 1'b1, 32'h100C, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0, 5);
        access("t4_rd_a", 1'b1, 1'b0, 32'h1008, 32'h0, 1'b0, 1'b1, 32'h1234, 5);
        access("t4_rd_b", 1'b1, 1'b0, 32'h100C, 32'h0, 1'b0, 1'b1, 32'hCAFE_F00D, 5);
        chk("t4_single_acks", 32'(ack_cnt - ack0), 32'd3);
        access("t4_wr3", 1'b0, 1'b1, 32'h3010, 32'hA5A5_0003, 1'b0, 1'b1, 32'hCAFE_F00D, 5);
        chk("t4_reg_ms3", 32'(last_ms), 32'h8);
        access("t4_rd3", 1'b1, 1'b0, 32'h3010, 32'h0, 1'b0, 1'b1, 32'hA5A5_0003, 5);
        ack_hold[1] = 1;

        // 6) write pulse while busy is dropped
        ack_dly[1] = 4;
        ms0 = ms_cyc; ack0 = ack_cnt;
        sb.push_back('{err: 1'b0, chk_rd: 1'b0, rdata: 32'h0, id: next_id});
        next_id++;
        @(negedge clk);
        pulse(1'b0, 1'b1, 32'h1010, 32'h55);
        pulse(1'b0, 1'b1, 32'h0000, 32'h66);
        wait_idle("t6");
        repeat (10) @(negedge clk);
        chk("t6_ms_cycles", 32'(ms_cyc - ms0), 32'd1);
        chk("t6_acks", 32'(ack_cnt - ack0), 32'd1);
        chk("t6_reg_ms", 32'(last_ms), 32'h2);
        access("t6_rd", 1'b1, 1'b0, 32'h1010, 32'h0, 1'b0, 1'b1, 32'h55, 7);

        // 5) reset during WAIT, late bank ack afterwards
        ack_dly[3] = 10;
        ack0 = ack_cnt;
        @(negedge clk);
        pulse(1'b1, 1'b0, 32'h3010, 32'h0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_ctrl", 32'({pio_busy, pio_ack, pio_err, clk_div, reg_rd, reg_wr, reg_ms}), 32'h0);
        chk("t5_rst_rdata", pio_rdata, 32'h0);
        chk("t5_rst_addr", reg_addr | reg_din, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("t5_no_late_ack", 32'(ack_cnt - ack0), 32'd0);
        ack_dly[3] = 2;
        access("t5_rd_after", 1'b1, 1'b0, 32'h3010, 32'h0, 1'b0, 1'b1, 32'hA5A5_0003, 5);

        repeat (5) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
